// File: rtl/sdr_cmd_arb_pkg.sv
// sdr_cmd_arb_pkg: shared SDRAM widths, FSM state encoding and the
// registered pin command record used by the command arbiter.
package sdr_cmd_arb_pkg;

    localparam int BA_WIDTH  = 2;
    localparam int ROW_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RW,
        ST_REF
    } state_t;

    typedef struct packed {
        logic                 ras_n;
        logic                 cas_n;
        logic                 we_n;
        logic [BA_WIDTH-1:0]  ba;
        logic [ROW_WIDTH:0]   addr;
    } sdr_cmd_t;

    localparam logic [2:0] NOP_RCW = 3'b111;

    // NOP keeps bank/address lines where they were to avoid needless toggling.
    function automatic sdr_cmd_t nop_hold(input sdr_cmd_t c);
        sdr_cmd_t n;
        n = c;
        {n.ras_n, n.cas_n, n.we_n} = NOP_RCW;
        return n;
    endfunction

endpackage

// File: rtl/sdr_cmd_arb_if.sv
// sdr_cmd_arb_if: command sources, arbitration handshake and SDRAM pins
// seen by sdr_cmd_arb (slave) and whatever drives it (master).
interface sdr_cmd_arb_if;
    import sdr_cmd_arb_pkg::*;

    logic                 Sdr_init_done;
    logic                 Sdr_ref_req;
    logic                 Sdr_init_ref_vld;
    logic                 Sdr_init_ref_ras;
    logic                 Sdr_init_ref_cas;
    logic                 Sdr_init_ref_we;
    logic [BA_WIDTH-1:0]  Sdr_init_ref_ba;
    logic [ROW_WIDTH:0]   Sdr_init_ref_addr;
    logic                 Rw_req;
    logic                 Rw_done;
    logic                 Rw_cmd_vld;
    logic                 Rw_ras;
    logic                 Rw_cas;
    logic                 Rw_we;
    logic [BA_WIDTH-1:0]  Rw_ba;
    logic [ROW_WIDTH:0]   Rw_addr;
    logic                 Sdr_ref_ack;
    logic                 Sdr_rw_vld;
    logic                 Rw_grant;
    logic                 Sdr_cs_n;
    logic                 Sdr_ras_n;
    logic                 Sdr_cas_n;
    logic                 Sdr_we_n;
    logic [BA_WIDTH-1:0]  Sdr_ba;
    logic [ROW_WIDTH:0]   Sdr_addr;
    logic                 Ref_ovf;
    logic                 Cmd_coll;

    modport master (
        output Sdr_init_done, Sdr_ref_req, Sdr_init_ref_vld, Sdr_init_ref_ras,
               Sdr_init_ref_cas, Sdr_init_ref_we, Sdr_init_ref_ba, Sdr_init_ref_addr,
               Rw_req, Rw_done, Rw_cmd_vld, Rw_ras, Rw_cas, Rw_we, Rw_ba, Rw_addr,
        input  Sdr_ref_ack, Sdr_rw_vld, Rw_grant, Sdr_cs_n, Sdr_ras_n, Sdr_cas_n,
               Sdr_we_n, Sdr_ba, Sdr_addr, Ref_ovf, Cmd_coll
    );

    modport slave (
        input  Sdr_init_done, Sdr_ref_req, Sdr_init_ref_vld, Sdr_init_ref_ras,
               Sdr_init_ref_cas, Sdr_init_ref_we, Sdr_init_ref_ba, Sdr_init_ref_addr,
               Rw_req, Rw_done, Rw_cmd_vld, Rw_ras, Rw_cas, Rw_we, Rw_ba, Rw_addr,
        output Sdr_ref_ack, Sdr_rw_vld, Rw_grant, Sdr_cs_n, Sdr_ras_n, Sdr_cas_n,
               Sdr_we_n, Sdr_ba, Sdr_addr, Ref_ovf, Cmd_coll
    );

endinterface

// File: rtl/sdr_ref_pend_cnt.sv
// sdr_ref_pend_cnt: saturating pending-refresh counter with sticky overflow.
module sdr_ref_pend_cnt #(
    parameter  int MAX = 8,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         Sdr_clk,
    input  logic         Rst,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_ovf
);

    logic [W-1:0] r_cnt;
    logic         r_ovf;

    always_ff @(posedge Sdr_clk) begin
        if (Rst) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec) begin
            if (r_cnt == W'(MAX))
                r_ovf <= 1'b1;
            else
                r_cnt <= r_cnt + 1'b1;
        end else if (i_dec && !i_inc && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/sdr_cmd_arb.sv
// sdr_cmd_arb: arbitrates the SDRAM bus between refresh and the read/write
// engine and registers the winning command onto the SDRAM pins.
module sdr_cmd_arb
    import sdr_cmd_arb_pkg::*;
#(
    parameter int REF_WIN      = 21,
    parameter int REF_PEND_MAX = 8
) (
    input logic          Sdr_clk,
    input logic          Rst,
    sdr_cmd_arb_if.slave bus
);

    localparam int WIN_W = $clog2(REF_WIN);
    localparam int CNT_W = $clog2(REF_PEND_MAX + 1);

    state_t             r_state;
    state_t             w_next;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [CNT_W-1:0]   w_ref_cnt;
    logic               w_ref_ovf;
    logic               w_ack;
    logic               w_clr;
    logic               w_sel_rw;
    logic               w_coll;
    logic               r_ack;
    logic               r_cs_n;
    logic               r_coll;
    sdr_cmd_t           r_cmd;
    sdr_cmd_t           w_ir_cmd;
    sdr_cmd_t           w_rw_cmd;

    sdr_ref_pend_cnt #(.MAX(REF_PEND_MAX)) u_pend (
        .Sdr_clk (Sdr_clk),
        .Rst     (Rst),
        .i_clr   (w_clr),
        .i_inc   (bus.Sdr_ref_req),
        .i_dec   (w_ack),
        .o_cnt   (w_ref_cnt),
        .o_ovf   (w_ref_ovf)
    );

    always_ff @(posedge Sdr_clk) begin
        if (Rst) begin
            r_state   <= ST_INIT;
            r_win_cnt <= '0;
            r_ack     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_win_cnt <= (r_state == ST_REF && w_next == ST_REF) ? r_win_cnt + 1'b1 : '0;
            r_ack     <= w_ack;
        end
    end

    // Pending refreshes beat a new Rw_req, but never cut into an RW burst.
    always_comb begin
        w_next = r_state;
        w_ack  = 1'b0;
        if (!bus.Sdr_init_done) begin
            w_next = ST_INIT;
        end else begin
            unique case (r_state)
                ST_INIT: w_next = ST_IDLE;
                ST_IDLE: begin
                    if (w_ref_cnt != '0) begin
                        w_next = ST_REF;
                        w_ack  = 1'b1;
                    end else if (bus.Rw_req) begin
                        w_next = ST_RW;
                    end
                end
                ST_RW:   w_next = bus.Rw_done ? ST_IDLE : ST_RW;
                ST_REF:  w_next = (r_win_cnt == WIN_W'(REF_WIN - 1)) ? ST_IDLE : ST_REF;
                default: w_next = ST_INIT;
            endcase
        end
    end

    // Clearing only on entry lets refresh requests accumulate while in INIT.
    assign w_clr    = !bus.Sdr_init_done && r_state != ST_INIT;
    assign w_sel_rw = r_state == ST_RW && bus.Rw_cmd_vld;
    assign w_coll   = bus.Sdr_init_ref_vld && w_sel_rw;
    assign w_ir_cmd = {bus.Sdr_init_ref_ras, bus.Sdr_init_ref_cas, bus.Sdr_init_ref_we,
                       bus.Sdr_init_ref_ba, bus.Sdr_init_ref_addr};
    assign w_rw_cmd = {bus.Rw_ras, bus.Rw_cas, bus.Rw_we, bus.Rw_ba, bus.Rw_addr};

    always_ff @(posedge Sdr_clk) begin
        if (Rst) begin
            r_cs_n <= 1'b1;
            r_cmd  <= '{ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1, ba: '0, addr: '0};
            r_coll <= 1'b0;
        end else begin
            r_cs_n <= 1'b0;
            r_cmd  <= bus.Sdr_init_ref_vld ? w_ir_cmd : w_sel_rw ? w_rw_cmd : nop_hold(r_cmd);
            r_coll <= r_coll | w_coll;
        end
    end

    assign bus.Sdr_ref_ack = r_ack;
    assign bus.Sdr_rw_vld  = r_state == ST_RW;
    assign bus.Rw_grant    = r_state == ST_RW;
    assign bus.Sdr_cs_n    = r_cs_n;
    assign bus.Sdr_ras_n   = r_cmd.ras_n;
    assign bus.Sdr_cas_n   = r_cmd.cas_n;
    assign bus.Sdr_we_n    = r_cmd.we_n;
    assign bus.Sdr_ba      = r_cmd.ba;
    assign bus.Sdr_addr    = r_cmd.addr;
    assign bus.Ref_ovf     = w_ref_ovf;
    assign bus.Cmd_coll    = r_coll;

endmodule

// File: tb/tb_sdr_cmd_arb.sv
// tb_sdr_cmd_arb: directed self-checking bench for sdr_cmd_arb.
module tb_sdr_cmd_arb;
    import sdr_cmd_arb_pkg::*;

    logic Sdr_clk = 1'b0;
    logic Rst     = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    int   n_ack, first, last, bad;

    sdr_cmd_arb_if bus();

    sdr_cmd_arb #(.REF_WIN(21), .REF_PEND_MAX(8)) dut (
        .Sdr_clk (Sdr_clk),
        .Rst     (Rst),
        .bus     (bus)
    );

    always #5 Sdr_clk = ~Sdr_clk;

    task automatic tick;
        @(posedge Sdr_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pins(input string tag, input logic r, input logic c, input logic w,
                            input logic [1:0] ba, input logic [12:0] addr);
        chk(tag, {13'd0, bus.Sdr_cs_n, bus.Sdr_ras_n, bus.Sdr_cas_n, bus.Sdr_we_n, bus.Sdr_ba, bus.Sdr_addr},
                 {13'd0, 1'b0, r, c, w, ba, addr});
    endtask

    // Runs from offset 2 to n; offset 1 is the current cycle. Records ack offsets,
    // flags wrong spacing and any ack overlapping rw_vld.
    task automatic watch_acks(input int n, output int cnt, output int f, output int l, output int b);
        cnt = 0; f = -1; l = -1; b = 0;
        for (int k = 2; k <= n; k++) begin
            tick;
            if (bus.Sdr_ref_ack) begin
                if (l >= 0 && k - l != 22) b++;
                if (bus.Sdr_rw_vld) b++;
                if (f < 0) f = k;
                l = k;
                cnt++;
            end
        end
    endtask

    task automatic pulse_ref;
        bus.Sdr_ref_req = 1'b1;
        tick;
        bus.Sdr_ref_req = 1'b0;
        tick;
    endtask

    initial begin
        bus.Sdr_init_done = 0; bus.Sdr_ref_req = 0; bus.Sdr_init_ref_vld = 0;
        bus.Sdr_init_ref_ras = 1; bus.Sdr_init_ref_cas = 1; bus.Sdr_init_ref_we = 1;
        bus.Sdr_init_ref_ba = 0; bus.Sdr_init_ref_addr = 0;
        bus.Rw_req = 0; bus.Rw_done = 0; bus.Rw_cmd_vld = 0;
        bus.Rw_ras = 1; bus.Rw_cas = 1; bus.Rw_we = 1; bus.Rw_ba = 0; bus.Rw_addr = 0;
        tick;
        tick;
        chk("reset_pins", {13'd0, bus.Sdr_cs_n, bus.Sdr_ras_n, bus.Sdr_cas_n, bus.Sdr_we_n, bus.Sdr_ba, bus.Sdr_addr},
                          {13'd0, 4'b1111, 2'd0, 13'd0});
        chk("reset_flags", {27'd0, bus.Sdr_ref_ack, bus.Rw_grant, bus.Sdr_rw_vld, bus.Ref_ovf, bus.Cmd_coll}, 32'd0);
        Rst = 1'b0;
        // init stream with an engine already asking for the bus
        bus.Rw_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            bus.Sdr_init_ref_vld  = 1'b1;
            bus.Sdr_init_ref_ras  = i[0];
            bus.Sdr_init_ref_cas  = i[1];
            bus.Sdr_init_ref_we   = i[2];
            bus.Sdr_init_ref_ba   = 2'(i);
            bus.Sdr_init_ref_addr = 13'(i * 37 + 1);
            tick;
            chk_pins("init_cmd", i[0], i[1], i[2], 2'(i), 13'(i * 37 + 1));
            chk("init_no_grant", {30'd0, bus.Rw_grant, bus.Sdr_rw_vld}, 32'd0);
        end
        bus.Sdr_init_ref_vld = 1'b0;
        tick;
        chk_pins("init_nop_hold", 1'b1, 1'b1, 1'b1, 2'd2, 13'd519);
        bus.Rw_req = 1'b0;
        bus.Sdr_init_done = 1'b1;
        tick;
        // single refresh: req at n, ack only at n+2, IDLE again at n+23
        bus.Sdr_ref_req = 1'b1;
        tick;
        bus.Sdr_ref_req = 1'b0;
        chk("ref_ack_n1", {31'd0, bus.Sdr_ref_ack}, 32'd0);
        tick;
        chk("ref_ack_n2", {30'd0, bus.Sdr_ref_ack, bus.Sdr_rw_vld}, 32'd2);
        bus.Rw_req = 1'b1;
        tick;
        chk("ref_ack_n3", {31'd0, bus.Sdr_ref_ack}, 32'd0);
        for (int i = 0; i < 20; i++) tick;
        chk("ref_win_hold", {31'd0, bus.Rw_grant}, 32'd0);
        tick;
        chk("ref_win_grant", {30'd0, bus.Rw_grant, bus.Sdr_rw_vld}, 32'd3);
        bus.Rw_req = 1'b0;
        // three refreshes queued behind an RW burst
        pulse_ref; pulse_ref; pulse_ref;
        chk("rw_not_preempted", {30'd0, bus.Rw_grant, bus.Sdr_ref_ack}, 32'd2);
        bus.Rw_done = 1'b1;
        tick;
        bus.Rw_done = 1'b0;
        chk("done_grant_drop", {31'd0, bus.Rw_grant}, 32'd0);
        watch_acks(70, n_ack, first, last, bad);
        chk("three_acks", 32'(n_ack), 32'd3);
        chk("three_first", 32'(first), 32'd2);
        chk("three_spacing", 32'(bad), 32'd0);
        // overflow while RW holds the bus
        bus.Rw_req = 1'b1;
        tick;
        bus.Rw_req = 1'b0;
        chk("ovf_grant", {31'd0, bus.Rw_grant}, 32'd1);
        for (int i = 0; i < 8; i++) pulse_ref;
        chk("ovf_not_yet", {31'd0, bus.Ref_ovf}, 32'd0);
        pulse_ref;
        chk("ovf_set", {31'd0, bus.Ref_ovf}, 32'd1);
        bus.Rw_done = 1'b1;
        tick;
        bus.Rw_done = 1'b0;
        watch_acks(190, n_ack, first, last, bad);
        chk("eight_acks", 32'(n_ack), 32'd8);
        chk("eight_last", 32'(last), 32'd156);
        chk("eight_spacing", 32'(bad), 32'd0);
        chk("ovf_sticky", {31'd0, bus.Ref_ovf}, 32'd1);
        // collision and Rw stream pass-through
        bus.Rw_req = 1'b1;
        tick;
        bus.Rw_req = 1'b0;
        bus.Sdr_init_ref_vld = 1'b1;
        {bus.Sdr_init_ref_ras, bus.Sdr_init_ref_cas, bus.Sdr_init_ref_we} = 3'b010;
        bus.Sdr_init_ref_ba = 2'd1; bus.Sdr_init_ref_addr = 13'h0400;
        bus.Rw_cmd_vld = 1'b1;
        {bus.Rw_ras, bus.Rw_cas, bus.Rw_we} = 3'b101;
        bus.Rw_ba = 2'd3; bus.Rw_addr = 13'h1abc;
        chk("coll_before", {31'd0, bus.Cmd_coll}, 32'd0);
        tick;
        chk_pins("coll_init_wins", 1'b0, 1'b1, 1'b0, 2'd1, 13'h0400);
        chk("coll_set", {31'd0, bus.Cmd_coll}, 32'd1);
        bus.Sdr_init_ref_vld = 1'b0;
        tick;
        chk_pins("rw_cmd", 1'b1, 1'b0, 1'b1, 2'd3, 13'h1abc);
        bus.Rw_cmd_vld = 1'b0;
        bus.Rw_done = 1'b1;
        tick;
        bus.Rw_done = 1'b0;
        chk_pins("rw_nop", 1'b1, 1'b1, 1'b1, 2'd3, 13'h1abc);
        bus.Rw_cmd_vld = 1'b1;
        {bus.Rw_ras, bus.Rw_cas, bus.Rw_we} = 3'b000;
        tick;
        bus.Rw_cmd_vld = 1'b0;
        chk_pins("rw_ignored_idle", 1'b1, 1'b1, 1'b1, 2'd3, 13'h1abc);
        // init drop mid-RW discards pending refreshes
        bus.Rw_req = 1'b1;
        tick;
        bus.Rw_req = 1'b0;
        pulse_ref; pulse_ref;
        chk("drop_in_rw", {31'd0, bus.Rw_grant}, 32'd1);
        bus.Sdr_init_done = 1'b0;
        tick;
        chk("drop_grant", {30'd0, bus.Rw_grant, bus.Sdr_rw_vld}, 32'd0);
        watch_acks(6, n_ack, first, last, bad);
        chk("drop_no_ack_init", 32'(n_ack), 32'd0);
        bus.Sdr_init_done = 1'b1;
        watch_acks(30, n_ack, first, last, bad);
        chk("drop_no_ack_after", 32'(n_ack), 32'd0);
        chk("coll_sticky", {31'd0, bus.Cmd_coll}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdr_cmd_arb.md
# sdr_cmd_arb

SDRAM command arbiter and pin driver sitting directly downstream of `sdr_init_ref`. It consumes the init/refresh command stream, its refresh request and its init-done flag. It arbitrates bus ownership between refresh and the read/write engine, returns `Sdr_ref_ack`/`Sdr_rw_vld` to `sdr_init_ref`, and registers the winning command onto the SDRAM command/address pins.

## Interface
Parameters:
- `REF_WIN`, default 21: cycles the bus is held for refresh after each ack. It covers `sdr_init_ref`'s 20-stage ack shift plus 1.
- `REF_PEND_MAX`, default 8: saturation limit of the pending-refresh counter.

Ports (`BA_WIDTH`, `ROW_WIDTH` come from the shared SDRAM defines):
- `Sdr_clk` in 1: clock.
- `Rst` in 1: reset, synchronous, active-high; clock `Sdr_clk`.
- `Sdr_init_done` in 1: init sequence complete.
- `Sdr_ref_req` in 1: single-cycle refresh request pulse.
- `Sdr_init_ref_vld` in 1: init/refresh command valid.
- `Sdr_init_ref_ras`, `Sdr_init_ref_cas`, `Sdr_init_ref_we` in 1 each: command pin levels (active-low encoding).
- `Sdr_init_ref_ba` in BA_WIDTH; `Sdr_init_ref_addr` in ROW_WIDTH+1.
- `Rw_req` in 1: read/write engine requests the bus; level, held until granted.
- `Rw_done` in 1: single-cycle pulse, engine releases the bus.
- `Rw_cmd_vld`, `Rw_ras`, `Rw_cas`, `Rw_we` in 1 each; `Rw_ba` in BA_WIDTH; `Rw_addr` in ROW_WIDTH+1.
- `Sdr_ref_ack` out 1: single-cycle refresh acknowledge.
- `Sdr_rw_vld` out 1: read/write engine owns the bus.
- `Rw_grant` out 1: grant level to the engine.
- `Sdr_cs_n`, `Sdr_ras_n`, `Sdr_cas_n`, `Sdr_we_n` out 1 each; `Sdr_ba` out BA_WIDTH; `Sdr_addr` out ROW_WIDTH+1.
- `Ref_ovf` out 1: sticky, pending counter saturated.
- `Cmd_coll` out 1: sticky, both command sources valid in the same cycle.

## Operation
FSM states: INIT, IDLE, RW, REF.
- INIT: only the init/refresh stream drives the pins; `Rw_grant`=0. Leaves to IDLE when `Sdr_init_done`=1.
- IDLE, evaluated in priority order:
  - `ref_cnt`≠0: go to REF, register `Sdr_ref_ack`=1 for exactly one cycle, decrement `ref_cnt`.
  - Otherwise, `Rw_req`=1: go to RW.
- RW: `Rw_grant`=`Sdr_rw_vld`=1. `Rw_done` returns to IDLE. Refresh is never preempted into an active RW burst; it waits for `Rw_done`.
- REF: the window counter runs 0..REF_WIN-1, then the FSM returns to IDLE. If refreshes are still pending, the next ack follows after one IDLE cycle.
- From any state, `Sdr_init_done`=0 forces INIT next cycle and clears `ref_cnt`. An RW in progress is aborted (grant drops). Init re-request mid-operation behaves this way.

Pending refresh counter `ref_cnt` (0..REF_PEND_MAX):
- Increments on `Sdr_ref_req`, including while in INIT.
- Decrements on ack.
- Simultaneous increment and decrement leaves it unchanged.
- An increment at REF_PEND_MAX saturates and sets `Ref_ovf`.

Command mux:
- Source selection: `Sdr_init_ref_vld` selects the init/refresh stream. Else, in RW with `Rw_cmd_vld`, the Rw stream is selected. Else NOP is driven: cs_n=0, ras_n=cas_n=we_n=1, ba/addr hold last value.
- `Rw_cmd_vld` outside RW is ignored.
- `Sdr_init_ref_vld` && `Rw_cmd_vld` in RW: init/refresh wins and `Cmd_coll` is set.

## Timing
- Reset values: state INIT, `ref_cnt`=0; cs_n=ras_n=cas_n=we_n=1; ba=0, addr=0; ack, grant, rw_vld, `Ref_ovf`, `Cmd_coll` all 0.
- Pins are registered: a source command in cycle n appears on the pins in cycle n+1.
- `Sdr_ref_req` in cycle n with FSM idle: `ref_cnt`=1 in n+1, `Sdr_ref_ack`=1 in n+2, `Sdr_rw_vld`=0 in that same cycle. This satisfies `sdr_init_ref`'s ack && !rw_vld sampling.
- `Rw_req` in IDLE at cycle n with no pending refresh: `Rw_grant` and `Sdr_rw_vld` = 1 from n+1.
- `Rw_done` at n: grant drops at n+1. Any pending ack can be issued at n+2 at the earliest.
- `Rw_req` and a pending refresh in the same IDLE cycle: refresh wins.
- Sticky flags clear only on `Rst`.

## Structure
- Shared package/defines: `BA_WIDTH`, `ROW_WIDTH`, NOP pin encoding, FSM state encoding.
- One natural sub-module, `sdr_ref_pend_cnt`: the saturating up/down counter with overflow flag.

## Test plan
- Reset, then `Sdr_init_done`=0 with an init stream of 15 valid commands: the pins mirror each command one cycle later, and `Rw_req`=1 gets no grant.
- `Sdr_init_done`=1, `Sdr_ref_req` pulse at cycle 10: ack high only at cycle 12, `Sdr_rw_vld`=0 there, bus returns to IDLE at cycle 12+21.
- In RW, 3 `Sdr_ref_req` pulses, `Rw_done` at cycle 50: three acks spaced REF_WIN+1 cycles apart, the first at cycle 52.
- 9 `Sdr_ref_req` pulses while RW is held: `ref_cnt`=8, `Ref_ovf`=1, and exactly 8 acks follow release.
- In RW, `Sdr_init_ref_vld` and `Rw_cmd_vld` high together: the init command appears on the pins and `Cmd_coll`=1.
- `Sdr_init_done` drops mid-RW with `ref_cnt`=2: `Rw_grant`=0 next cycle, `ref_cnt`=0, and no ack until re-init completes.
